// File: rtl/alu_seq_pkg.sv
// Control codes and multiply/divide FSM encodings shared by the alu_seq files.
package alu_seq_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SLTU  = 4'b0011;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_MULT  = 4'b1000;
   localparam logic [3:0] ALU_MULTU = 4'b1001;
   localparam logic [3:0] ALU_DIV   = 4'b1010;
   localparam logic [3:0] ALU_DIVU  = 4'b1011;
   localparam logic [3:0] ALU_NOR   = 4'b1100;
   localparam logic [3:0] ALU_XOR   = 4'b1101;

   localparam logic [1:0] ALU_ST_IDLE = 2'd0;
   localparam logic [1:0] ALU_ST_RUN  = 2'd1;
   localparam logic [1:0] ALU_ST_FIX  = 2'd2;

   // Codes 1000..1011; bit 1 selects divide, bit 0 selects unsigned.
   function automatic logic is_muldiv(input logic [3:0] code);
      return code[3:2] == 2'b10;
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Unsigned iterative core: shift-add multiply or restoring divide, one bit per step.
module alu_muldiv_iter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             last_o
);

   logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, m_q, m_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   add_sum, rem_sh, rem_diff;

   always_comb begin
      add_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      rem_sh   = {acc_q, lo_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, m_q};
      acc_d    = acc_q;
      lo_d     = lo_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      if (load_i) begin
         acc_d = '0;
         lo_d  = op_a_i;
         m_d   = op_b_i;
         cnt_d = CNT_W'(WIDTH - 1);
      end else if (step_i) begin
         cnt_d = cnt_q - 1'b1;
         if (is_div_i) begin
            // Negative trial difference means restore: keep the shifted remainder.
            acc_d = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
         end else begin
            acc_d = add_sum[WIDTH:1];
            lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         acc_q <= '0;
         lo_q  <= '0;
         m_q   <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         lo_q  <= lo_d;
         m_q   <= m_d;
         cnt_q <= cnt_d;
      end
   end

   assign acc_o  = acc_q;
   assign lo_o   = lo_q;
   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Registered MIPS EX-stage ALU; multiply/divide with HI/LO exists only when
// ALU_SEQ_MULDIV_EN is defined.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ctl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

`ifdef ALU_SEQ_MULDIV_EN
   localparam bit MulDivEn = 1'b1;
`else
   localparam bit MulDivEn = 1'b0;
`endif

   logic [WIDTH-1:0] out_q, out_d, alu_res, sum, diff;
   logic             ovf_q, ovf_d, alu_ovf, add_ovf, sub_ovf;
   logic             done_q, done_d, single_go, fix_done;

   assign sum     = a + b;
   assign diff    = a - b;
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (ctl)
         ALU_AND:  alu_res = a & b;
         ALU_OR:   alu_res = a | b;
         ALU_ADD:  begin alu_res = sum;  alu_ovf = add_ovf; end
         ALU_SUB:  begin alu_res = diff; alu_ovf = sub_ovf; end
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
         ALU_NOR:  alu_res = ~(a | b);
         ALU_XOR:  alu_res = a ^ b;
         default:  alu_res = '0;
      endcase
   end

   assign single_go = start & ~busy & ~(MulDivEn & is_muldiv(ctl));

   always_comb begin
      out_d  = single_go ? alu_res : out_q;
      ovf_d  = single_go ? alu_ovf : ovf_q;
      done_d = single_go | fix_done;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q  <= '0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         ovf_q  <= ovf_d;
         done_q <= done_d;
      end
   end

   assign out      = out_q;
   assign zero     = (out_q == '0);
   assign overflow = ovf_q;
   assign done     = done_q;

`ifdef ALU_SEQ_MULDIV_EN
   logic [1:0]         state_q, state_d;
   logic               is_div_q, is_div_d, neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d, dbz_q, dbz_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mag_a, mag_b, md_acc, md_lo;
   logic [2*WIDTH-1:0] prod;
   logic               a_neg, b_neg, md_go, md_load, md_step, md_last;

   // Signed ops run on magnitudes; signs are re-applied in FIX.
   assign a_neg = ~ctl[0] & a[WIDTH-1];
   assign b_neg = ~ctl[0] & b[WIDTH-1];
   assign mag_a = a_neg ? -a : a;
   assign mag_b = b_neg ? -b : b;
   assign md_go = start & ~busy & is_muldiv(ctl);
   assign prod  = {md_acc, md_lo};

   always_comb begin
      state_d   = state_q;
      is_div_d  = is_div_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      md_load   = 1'b0;
      md_step   = 1'b0;
      fix_done  = 1'b0;
      case (state_q)
         ALU_ST_IDLE: begin
            if (md_go) begin
               state_d   = ALU_ST_RUN;
               md_load   = 1'b1;
               is_div_d  = ctl[1];
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               dbz_d     = (b == '0);
            end
         end
         ALU_ST_RUN: begin
            md_step = 1'b1;
            if (md_last) state_d = ALU_ST_FIX;
         end
         ALU_ST_FIX: begin
            state_d  = ALU_ST_IDLE;
            fix_done = 1'b1;
            if (is_div_q) begin
               lo_d = dbz_q ? '1 : (neg_quo_q ? -md_lo : md_lo);
               hi_d = neg_rem_q ? -md_acc : md_acc;
            end else begin
               {hi_d, lo_d} = neg_quo_q ? -prod : prod;
            end
         end
         default: state_d = ALU_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ALU_ST_IDLE;
         is_div_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         is_div_q  <= is_div_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   alu_muldiv_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk_i    (clk),
      .reset_i  (reset),
      .load_i   (md_load),
      .step_i   (md_step),
      .is_div_i (is_div_q),
      .op_a_i   (mag_a),
      .op_b_i   (mag_b),
      .acc_o    (md_acc),
      .lo_o     (md_lo),
      .last_o   (md_last)
   );

   assign busy = (state_q != ALU_ST_IDLE);
   assign hi   = hi_q;
   assign lo   = lo_q;
`else
   assign busy     = 1'b0;
   assign hi       = '0;
   assign lo       = '0;
   assign fix_done = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8 against a math-level reference model.
module tb_alu_seq;

`ifdef ALU_SEQ_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   typedef struct packed {
      logic        multi;
      logic [31:0] out;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        ovf;
      logic [31:0] cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_v [2];
   logic        start_v [2];
   logic [3:0]  ctl_v [2];
   logic [31:0] a_v [2];
   logic [31:0] b_v [2];
   logic [31:0] out_w [2], hi_w [2], lo_w [2];
   logic        zero_w [2], ovf_w [2], busy_w [2], done_w [2];

   logic [31:0] out32, hi32, lo32;
   logic [7:0]  out8, hi8, lo8;
   logic        zero32, ovf32, busy32, done32, zero8, ovf8, busy8, done8;

   alu_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .ctl(ctl_v[0]), .a(a_v[0]), .b(b_v[0]),
      .out(out32), .zero(zero32), .overflow(ovf32), .hi(hi32), .lo(lo32), .busy(busy32),
      .done(done32)
   );

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .ctl(ctl_v[1]), .a(a_v[1][7:0]),
      .b(b_v[1][7:0]), .out(out8), .zero(zero8), .overflow(ovf8), .hi(hi8), .lo(lo8),
      .busy(busy8), .done(done8)
   );

   assign out_w[0] = out32;           assign out_w[1] = {24'd0, out8};
   assign hi_w[0]  = hi32;            assign hi_w[1]  = {24'd0, hi8};
   assign lo_w[0]  = lo32;            assign lo_w[1]  = {24'd0, lo8};
   assign zero_w[0] = zero32;         assign zero_w[1] = zero8;
   assign ovf_w[0]  = ovf32;          assign ovf_w[1]  = ovf8;
   assign busy_w[0] = busy32;         assign busy_w[1] = busy8;
   assign done_w[0] = done32;         assign done_w[1] = done8;

   exp_t        sb0[$], sb1[$];
   logic [31:0] last_out [2], last_hi [2], last_lo [2];
   logic        last_ovf [2];
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input int d, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)", name, d, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the operands interpreted at width w.
   function automatic exp_t model(input int w, input logic [3:0] c, input logic [31:0] av,
                                  input logic [31:0] bv);
      exp_t        e;
      logic [63:0] mask, ua, ub, t, th;
      longint      one, sa, sb, mn, mx, r;
      one  = 1;
      mask = (64'd1 << w) - 64'd1;
      ua   = {32'd0, av} & mask;
      ub   = {32'd0, bv} & mask;
      mn   = -(one << (w - 1));
      mx   = (one << (w - 1)) - 1;
      sa   = ua[w-1] ? longint'(ua) - (one << w) : longint'(ua);
      sb   = ub[w-1] ? longint'(ub) - (one << w) : longint'(ub);
      e    = '0;
      t    = '0;
      th   = '0;
      e.multi = MD && (c[3:2] == 2'b10);
      case (c)
         4'b0000: t = ua & ub;
         4'b0001: t = ua | ub;
         4'b0010: begin r = sa + sb; e.ovf = (r > mx) || (r < mn); t = r; end
         4'b0110: begin r = sa - sb; e.ovf = (r > mx) || (r < mn); t = r; end
         4'b0111: t = (sa < sb) ? 64'd1 : 64'd0;
         4'b0011: t = (ua < ub) ? 64'd1 : 64'd0;
         4'b1100: t = ~(ua | ub);
         4'b1101: t = ua ^ ub;
         4'b1000: if (MD) begin r = sa * sb; t = r; th = t >> w; end
         4'b1001: if (MD) begin t = ua * ub; th = t >> w; end
         4'b1010: if (MD) begin
            if (ub == 0) begin t = mask; th = ua; end
            else if (sa == mn && sb == -1) begin t = ua; th = 0; end
            else begin r = sa / sb; t = r; r = sa % sb; th = r; end
         end
         4'b1011: if (MD) begin
            if (ub == 0) begin t = mask; th = ua; end
            else begin t = ua / ub; th = ua % ub; end
         end
         default: t = '0;
      endcase
      if (e.multi) begin
         e.lo = 32'(t & mask);
         e.hi = 32'(th & mask);
      end else begin
         e.out = 32'(t & mask);
      end
      return e;
   endfunction

   task automatic sb_pop(input int d, output exp_t e, output logic ok);
      e  = '0;
      ok = 1'b0;
      if (d == 0) begin
         if (sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
      end else begin
         if (sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_mon
      always @(negedge clk) begin
         exp_t e;
         logic ok;
         if (done_w[g] === 1'b1) begin
            sb_pop(g, e, ok);
            chk("done_expected", g, ok, 1);
            if (ok) begin
               chk("done_cycle", g, cyc, e.cyc);
               chk("busy_at_done", g, busy_w[g], 0);
               chk("out", g, out_w[g], e.out);
               chk("zero", g, zero_w[g], e.out == 0);
               chk("overflow", g, ovf_w[g], e.ovf);
               chk("hi", g, hi_w[g], e.hi);
               chk("lo", g, lo_w[g], e.lo);
            end
         end
      end
   end

   task automatic issue(input int d, input logic [3:0] c, input logic [31:0] av,
                        input logic [31:0] bv, output logic multi);
      exp_t e;
      int   w, n;
      w = (d == 0) ? 32 : 8;
      n = 0;
      while (busy_w[d] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("idle_timeout", d, busy_w[d], 0);
      e     = model(w, c, av, bv);
      e.cyc = cyc + 1 + (e.multi ? w + 1 : 0);
      if (e.multi) begin
         e.out = last_out[d];
         e.ovf = last_ovf[d];
         last_hi[d] = e.hi;
         last_lo[d] = e.lo;
      end else begin
         e.hi = last_hi[d];
         e.lo = last_lo[d];
         last_out[d] = e.out;
         last_ovf[d] = e.ovf;
      end
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
      multi      = e.multi;
      start_v[d] = 1'b1;
      ctl_v[d]   = c;
      a_v[d]     = av;
      b_v[d]     = bv;
      @(negedge clk);
      start_v[d] = 1'b0;
      ctl_v[d]   = 4'($urandom);
      a_v[d]     = $urandom;
      b_v[d]     = $urandom;
      chk("busy_after_start", d, busy_w[d], e.multi);
   endtask

   // Start pulse while busy: must be dropped, so nothing is expected.
   task automatic poke(input int d);
      start_v[d] = 1'b1;
      ctl_v[d]   = 4'b0010;
      a_v[d]     = $urandom;
      b_v[d]     = $urandom;
      @(negedge clk);
      start_v[d] = 1'b0;
   endtask

   task automatic do_reset(input int d);
      rst_v[d] = 1'b1;
      @(negedge clk);
      rst_v[d] = 1'b0;
      if (d == 0) sb0.delete(); else sb1.delete();
      last_out[d] = '0;
      last_hi[d]  = '0;
      last_lo[d]  = '0;
      last_ovf[d] = 1'b0;
      chk("rst_busy", d, busy_w[d], 0);
      chk("rst_done", d, done_w[d], 0);
      chk("rst_hi", d, hi_w[d], 0);
      chk("rst_lo", d, lo_w[d], 0);
      chk("rst_out", d, out_w[d], 0);
      chk("rst_zero", d, zero_w[d], 1);
      chk("rst_overflow", d, ovf_w[d], 0);
   endtask

   function automatic logic [31:0] rnd(input int w);
      logic [31:0] mask, v;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'd1;
         2: v = mask;
         3: v = 32'd1 << (w - 1);
         4: v = mask >> 1;
         default: v = $urandom;
      endcase
      return v & mask;
   endfunction

   initial begin
      logic m;
      int   n;
      for (int d = 0; d < 2; d++) begin
         rst_v[d] = 1'b1; start_v[d] = 1'b0; ctl_v[d] = '0; a_v[d] = '0; b_v[d] = '0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) do_reset(d);

      issue(0, 4'b0010, 32'h7FFF_FFFF, 32'd1, m);
      issue(0, 4'b0110, 32'd5, 32'd5, m);
      issue(0, 4'b0111, 32'h8000_0000, 32'd1, m);
      issue(0, 4'b0011, 32'h8000_0000, 32'd1, m);
      issue(0, 4'b0101, 32'h1234_5678, 32'h0F0F_0F0F, m);
      issue(0, 4'b1000, 32'hFFFF_FFFD, 32'd7, m);
      if (m) begin @(negedge clk); poke(0); end
      issue(0, 4'b1001, 32'hFFFF_FFFD, 32'd7, m);
      issue(0, 4'b1010, 32'hFFFF_FFF9, 32'd2, m);
      issue(0, 4'b1011, 32'd100, 32'd0, m);
      issue(0, 4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, m);
      issue(0, 4'b1010, 32'hFFFF_FFF9, 32'd0, m);

      // Abort a divide partway through RUN, then confirm a fresh start is taken.
      issue(0, 4'b1010, 32'd1000, 32'd7, m);
      repeat (4) @(negedge clk);
      do_reset(0);
      issue(0, 4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, m);

      issue(1, 4'b1001, 32'hFF, 32'hFF, m);
      if (m) poke(1);
      issue(1, 4'b0010, 32'h7F, 32'h01, m);

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 40; i++) begin
            issue(d, 4'($urandom_range(0, 15)), rnd(d == 0 ? 32 : 8), rnd(d == 0 ? 32 : 8), m);
            if (m && $urandom_range(0, 1) == 1) poke(d);
         end
      end

      n = 0;
      while ((sb0.size() + sb1.size()) > 0 && n < 200) begin @(negedge clk); n++; end
      chk("drain_queue", 0, sb0.size() + sb1.size(), 0);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised next-generation ALU for the MIPS datapath.
- Same single-cycle logic and compare operations as before, with the result now registered.
- Adds unsigned set-less-than and an exported overflow flag.
- Adds iterative signed/unsigned multiply and divide writing HI/LO registers, driven by a start/busy/done handshake.
- Sits in EX; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, datapath width in bits; must be at least 4.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter; derived, do not override.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset; one clock, reset is synchronous and active-high.
- start, input, 1, launch the operation in ctl on a/b; sampled only when busy=0.
- ctl, input, 4, operation code.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- out, output, WIDTH, registered result of single-cycle ops.
- zero, output, 1, out == 0.
- overflow, output, 1, signed overflow of the last ADD/SUB; 0 for other ops.
- hi, output, WIDTH, multiply high word or divide remainder.
- lo, output, WIDTH, multiply low word or divide quotient.
- busy, output, 1, multi-cycle operation in progress.
- done, output, 1, one-cycle pulse: result valid.

Behaviour:
- Reset: out=0, hi=0, lo=0, overflow=0, busy=0, done=0, state=IDLE. Reset mid-operation aborts the operation; hi/lo are cleared.
- Single-cycle codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, overflow-corrected), 0011 SLTU, 1100 NOR, 1101 XOR.
  - Any other code not listed below: out=0.
- Multi-cycle codes: 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU.
- Single-cycle op: start at edge k. out/overflow are updated at edge k; done=1 for the cycle after edge k; busy stays 0.
- out holds between starts; zero is combinational from out.
- ADD/SUB wrap modulo 2^WIDTH.
- overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operand signs differ and the result sign differs from a.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on start with a multi-cycle code. Operands are latched as magnitudes for signed ops; result signs are recorded.
  - RUN runs WIDTH iterations: shift-add for multiply, restoring shift-subtract for divide. Counter runs WIDTH-1 down to 0.
  - RUN -> FIX when the counter reaches 0.
  - FIX applies sign correction and writes hi/lo. FIX -> IDLE.
- Multi-cycle latency:
  - start at edge k; busy=1 from edge k through edge k+WIDTH+1.
  - hi/lo are written at edge k+WIDTH+1; done=1 for the following cycle, with busy=0.
  - Total latency WIDTH+2 edges.
- start while busy=1 is ignored; no queueing. out is unchanged during RUN/FIX.
- Signed multiply: {hi,lo} is the 2*WIDTH two's-complement product.
- Signed divide:
  - Quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
  - INT_MIN / -1 gives lo=INT_MIN, hi=0.
- Divide by zero (both signednesses): lo = all ones, hi = a. Still takes full latency; no exception.
- ctl, a and b may change after the start edge without effect.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: multiply/divide, hi/lo, RUN/FIX states as above.
- Undefined:
  - Codes 1000-1011 behave as unknown codes: out=0, single-cycle done.
  - busy is tied 0; hi/lo are tied 0.
  - FSM and counter are not synthesised.

Decomposition:
- Shared include file alu_defs.vh, under its own `ifndef guard, holds:
  - ctl code `defines (ALU_AND .. ALU_DIVU);
  - FSM state encodings (ALU_ST_IDLE/RUN/FIX).
- One natural sub-module: alu_muldiv_iter, the RUN-state datapath (shift-add/shift-subtract core plus counter, WIDTH parameter).
- alu_seq holds the combinational ops, sign pre/post-processing and the FSM.

Test Plan:
- Reset asserted mid-DIV at RUN cycle 5 -> next cycle busy=0, hi=lo=0, done=0; a new start is then accepted.
- ADD a=0x7FFFFFFF, b=1 -> out=0x80000000, overflow=1, zero=0, done one cycle after start. SUB a=5, b=5 -> out=0, zero=1, overflow=0.
- SLT a=0x80000000, b=1 -> out=1; SLTU same operands -> out=0. Unknown ctl 0101 -> out=0, zero=1.
- MULT a=-3 (0xFFFFFFFD), b=7 -> after 34 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse exactly 1 cycle. MULTU same operands -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- start pulsed with ADD while busy during MULT -> ignored: out unchanged, MULT result correct. Repeat at WIDTH=8: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01, latency 10.
